// File: rtl/icache.sv
// Direct-mapped, one-word-block instruction cache with a two-state miss FSM.
// Hits are combinational in IDLE; misses are filled from memory and then re-looked-up.
module icache #(
   parameter int SETS  = 16,
   parameter int CNT_W = 32
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             imemREN,
   input  logic [31:0]      imemaddr,
   output logic             ihit,
   output logic [31:0]      imemload,
   input  logic             flush,
   output logic             iREN,
   output logic [31:0]      iaddr,
   input  logic             iwait,
   input  logic [31:0]      iload,
   output logic [CNT_W-1:0] hit_count,
   output logic [CNT_W-1:0] miss_count
);

   localparam int IDX_W = $clog2(SETS);
   localparam int TAG_W = 30 - IDX_W;

   typedef enum logic {IDLE, FETCH} state_t;

   state_t           state;
   logic [SETS-1:0]  valid;
   logic [TAG_W-1:0] tags [SETS];
   logic [31:0]      data [SETS];

   logic [IDX_W-1:0] req_idx;
   logic [TAG_W-1:0] req_tag;
   logic [IDX_W-1:0] miss_idx;
   logic [TAG_W-1:0] miss_tag;
   logic             lookup;
   logic             start_miss;
   logic             unused_addr_bits;

   assign req_idx  = imemaddr[IDX_W+1:2];
   assign req_tag  = imemaddr[31:IDX_W+2];

   // iaddr holds the miss address for the whole fill, so it doubles as miss_addr.
   assign miss_idx = iaddr[IDX_W+1:2];
   assign miss_tag = iaddr[31:IDX_W+2];

   assign lookup     = imemREN && valid[req_idx] && (tags[req_idx] == req_tag);
   assign ihit       = (state == IDLE) && lookup && !flush;
   assign imemload   = data[req_idx];
   assign start_miss = (state == IDLE) && imemREN && !lookup && !flush;

   assign unused_addr_bits = ^{imemaddr[1:0], iaddr[1:0]};

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state      <= IDLE;
         valid      <= '0;
         iREN       <= 1'b0;
         iaddr      <= '0;
         hit_count  <= '0;
         miss_count <= '0;
         for (int i = 0; i < SETS; i++) begin
            tags[i] <= '0;
            data[i] <= '0;
         end
      end else begin
         hit_count <= hit_count + CNT_W'(ihit);
         case (state)
            IDLE: begin
               if (start_miss) begin
                  state      <= FETCH;
                  iREN       <= 1'b1;
                  iaddr      <= {imemaddr[31:2], 2'b00};
                  miss_count <= miss_count + CNT_W'(1);
               end
            end
            FETCH: begin
               if (!iwait) begin
                  data[miss_idx]  <= iload;
                  tags[miss_idx]  <= miss_tag;
                  valid[miss_idx] <= 1'b1;
                  state           <= IDLE;
                  iREN            <= 1'b0;
                  iaddr           <= '0;
               end
            end
            default: state <= IDLE;
         endcase
         // Placed last so a flush overrides a valid-set from a fill in the same cycle.
         if (flush) valid <= '0;
      end
   end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed vector table, hand-written corner
// sequences, then randomized accesses checked against a frame-map reference model.
module tb_icache;

   localparam int SETS  = 16;
   localparam int CNT_W = 32;

   logic             CLK;
   logic             nRST;
   logic             imemREN;
   logic [31:0]      imemaddr;
   logic             ihit;
   logic [31:0]      imemload;
   logic             flush;
   logic             iREN;
   logic [31:0]      iaddr;
   logic             iwait;
   logic [31:0]      iload;
   logic [CNT_W-1:0] hit_count;
   logic [CNT_W-1:0] miss_count;

   icache #(.SETS(SETS), .CNT_W(CNT_W)) dut (
      .CLK        (CLK),
      .nRST       (nRST),
      .imemREN    (imemREN),
      .imemaddr   (imemaddr),
      .ihit       (ihit),
      .imemload   (imemload),
      .flush      (flush),
      .iREN       (iREN),
      .iaddr      (iaddr),
      .iwait      (iwait),
      .iload      (iload),
      .hit_count  (hit_count),
      .miss_count (miss_count)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int checks   = 0;
   int failures = 0;

   // Reference model: which word address each frame holds, and its data.
   bit          ref_valid [SETS];
   logic [29:0] ref_line  [SETS];
   logic [31:0] ref_data  [SETS];
   int unsigned ref_hits;
   int unsigned ref_misses;

   typedef struct {
      logic [31:0] addr;
      int          nwait;
      logic [31:0] load;
      bit          exp_hit;
   } vec_t;

   vec_t vecs [9];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int frame_of(input logic [31:0] a);
      return int'((a >> 2) % SETS);
   endfunction

   function automatic bit predict(input logic [31:0] a);
      int f;
      f = frame_of(a);
      return ref_valid[f] && (ref_line[f] == a[31:2]);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < SETS; i++) begin
         ref_valid[i] = 1'b0;
         ref_line[i]  = '0;
         ref_data[i]  = '0;
      end
      ref_hits   = 0;
      ref_misses = 0;
   endtask

   task automatic model_flush();
      for (int i = 0; i < SETS; i++) ref_valid[i] = 1'b0;
   endtask

   task automatic check_counters(input string tag);
      checkOutput({tag, " hit_count"},  hit_count,  ref_hits);
      checkOutput({tag, " miss_count"}, miss_count, ref_misses);
   endtask

   // One fetch of addr. On a miss the memory answers after nwait busy cycles
   // with load; flush_fill raises flush in the fill cycle, in which case the
   // re-lookup cycle is left to the caller.
   task automatic applyStimulus(input logic [31:0] addr, input bit exp_hit, input int nwait,
                                input logic [31:0] load, input bit flush_fill);
      int f;
      f = frame_of(addr);
      imemREN  = 1'b1;
      imemaddr = addr;
      flush    = 1'b0;
      iwait    = 1'b1;
      iload    = $urandom;
      @(negedge CLK);
      checkOutput("lookup ihit", {31'b0, ihit}, {31'b0, exp_hit});
      checkOutput("lookup iREN", {31'b0, iREN}, 32'd0);
      if (exp_hit) begin
         checkOutput("hit imemload", imemload, ref_data[f]);
         ref_hits++;
         @(posedge CLK); #1;
         return;
      end
      ref_misses++;
      @(posedge CLK); #1;
      for (int k = 0; k <= nwait; k++) begin
         iwait = (k < nwait);
         iload = (k < nwait) ? $urandom : load;
         flush = (k == nwait) && flush_fill;
         @(negedge CLK);
         checkOutput("fetch iREN",  {31'b0, iREN}, 32'd1);
         checkOutput("fetch iaddr", iaddr, {addr[31:2], 2'b00});
         checkOutput("fetch ihit",  {31'b0, ihit}, 32'd0);
         @(posedge CLK); #1;
      end
      flush         = 1'b0;
      ref_data[f]   = load;
      ref_line[f]   = addr[31:2];
      ref_valid[f]  = 1'b1;
      if (flush_fill) model_flush();
      if (!flush_fill) begin
         @(negedge CLK);
         checkOutput("refill ihit",     {31'b0, ihit}, 32'd1);
         checkOutput("refill imemload", imemload, load);
         ref_hits++;
         @(posedge CLK); #1;
      end
   endtask

   // A single flush cycle, optionally with a request present.
   task automatic flush_cycle(input logic [31:0] addr, input bit req);
      imemREN  = req;
      imemaddr = addr;
      flush    = 1'b1;
      iwait    = 1'b1;
      @(negedge CLK);
      checkOutput("flush ihit", {31'b0, ihit}, 32'd0);
      @(posedge CLK); #1;
      flush = 1'b0;
      model_flush();
      imemREN = 1'b0;
      checkOutput("flush no miss iREN", {31'b0, iREN}, 32'd0);
   endtask

   task automatic release_reset();
      @(negedge CLK); #2;
      nRST = 1'b1;
      #1;
      checkOutput("post-release ihit",     {31'b0, ihit}, 32'd0);
      checkOutput("post-release imemload", imemload, 32'd0);
      @(posedge CLK); #1;
   endtask

   initial begin
      logic [31:0] a;
      int unsigned hits_before;
      int          r;

      vecs[0] = '{32'h40, 3, 32'h2001000A, 1'b0};  // cold miss, 3 busy cycles
      vecs[1] = '{32'h80, 0, 32'h11110080, 1'b0};  // conflicts with 0x40
      vecs[2] = '{32'h40, 1, 32'h2001000A, 1'b0};  // evicted, misses again
      vecs[3] = '{32'h00, 0, 32'hA0000000, 1'b0};
      vecs[4] = '{32'h04, 2, 32'hA0000004, 1'b0};
      vecs[5] = '{32'h08, 0, 32'hA0000008, 1'b0};
      vecs[6] = '{32'h00, 0, 32'h0,        1'b1};  // hit streak
      vecs[7] = '{32'h04, 0, 32'h0,        1'b1};
      vecs[8] = '{32'h08, 0, 32'h0,        1'b1};

      model_reset();
      nRST     = 1'b0;
      imemREN  = 1'b0;
      imemaddr = '0;
      flush    = 1'b0;
      iwait    = 1'b1;
      iload    = '0;
      #3;
      checkOutput("reset iREN",       {31'b0, iREN}, 32'd0);
      checkOutput("reset iaddr",      iaddr, 32'd0);
      checkOutput("reset ihit",       {31'b0, ihit}, 32'd0);
      checkOutput("reset imemload",   imemload, 32'd0);
      check_counters("reset");
      repeat (2) @(posedge CLK);
      release_reset();

      hits_before = 0;
      for (int i = 0; i < 9; i++) begin
         if (i == 6) hits_before = ref_hits;
         applyStimulus(vecs[i].addr, vecs[i].exp_hit, vecs[i].nwait, vecs[i].load, 1'b0);
         if (vecs[i].exp_hit) checkOutput("streak iREN", {31'b0, iREN}, 32'd0);
         check_counters("vector");
         if (i == 0) checkOutput("cold miss_count", miss_count, 32'd1);
         if (i == 2) checkOutput("conflict miss_count", miss_count, 32'd3);
      end
      checkOutput("streak hit_count", hit_count, hits_before + 3);

      // Flush after 0x00 is resident: next request must miss.
      flush_cycle(32'h00, 1'b1);
      check_counters("flush");
      applyStimulus(32'h00, 1'b0, 0, 32'hB0000000, 1'b0);

      // Flush in the fill cycle: frame is written but stays invalid.
      applyStimulus(32'h100, 1'b0, 1, 32'hC0000100, 1'b1);
      applyStimulus(32'h100, 1'b0, 0, 32'hC0000101, 1'b0);
      check_counters("flush-fill");

      // Fill for 0x10 survives imemaddr changing and imemREN dropping.
      imemREN  = 1'b1;
      imemaddr = 32'h10;
      iwait    = 1'b1;
      @(negedge CLK);
      checkOutput("abort lookup ihit", {31'b0, ihit}, 32'd0);
      ref_misses++;
      @(posedge CLK); #1;
      imemaddr = 32'h20;
      imemREN  = 1'b0;
      @(negedge CLK);
      checkOutput("abort iaddr busy", iaddr, 32'h10);
      @(posedge CLK); #1;
      iwait = 1'b0;
      iload = 32'hCAFE0004;
      @(negedge CLK);
      checkOutput("abort iaddr fill", iaddr, 32'h10);
      checkOutput("abort iREN fill", {31'b0, iREN}, 32'd1);
      @(posedge CLK); #1;
      iwait = 1'b1;
      ref_valid[4] = 1'b1;
      ref_line[4]  = 30'h4;
      ref_data[4]  = 32'hCAFE0004;
      checkOutput("abort idle iREN",  {31'b0, iREN}, 32'd0);
      checkOutput("abort idle iaddr", iaddr, 32'd0);
      applyStimulus(32'h10, 1'b1, 0, 32'h0, 1'b0);
      check_counters("abort");

      // Asynchronous reset while a fill is outstanding.
      imemREN  = 1'b1;
      imemaddr = 32'h44;
      iwait    = 1'b1;
      @(posedge CLK); #1;
      @(negedge CLK);
      checkOutput("midfetch iREN", {31'b0, iREN}, 32'd1);
      #2;
      nRST    = 1'b0;
      imemREN = 1'b0;
      #1;
      model_reset();
      checkOutput("async iREN",  {31'b0, iREN}, 32'd0);
      checkOutput("async iaddr", iaddr, 32'd0);
      check_counters("async");
      repeat (2) @(posedge CLK);
      release_reset();
      check_counters("after reset");
      applyStimulus(32'h10, 1'b0, 0, 32'hD0000010, 1'b0);
      applyStimulus(32'h08, 1'b0, 1, 32'hD0000008, 1'b0);

      // Randomized traffic against the reference model.
      for (int n = 0; n < 250; n++) begin
         r = int'($urandom_range(0, 9));
         a = 32'($urandom_range(0, 47)) << 2;
         if (r == 0) begin
            flush_cycle(a, 1'b1);
         end else if (r == 1) begin
            imemREN = 1'b0;
            flush   = 1'b0;
            @(negedge CLK);
            checkOutput("idle ihit", {31'b0, ihit}, 32'd0);
            checkOutput("idle iREN", {31'b0, iREN}, 32'd0);
            @(posedge CLK); #1;
         end else begin
            applyStimulus(a, predict(a), int'($urandom_range(0, 3)), $urandom,
                          ($urandom_range(0, 9) == 0));
         end
         check_counters("random");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
